// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and helpers for the single-cycle MIPS datapath
package mips_pkg;

  // Machine word and register-file geometry
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  // alucontrol encodings produced by the ALU decoder
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Sequential fetch stride in bytes
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Sign-extend a 16-bit immediate to a full word
  function automatic logic [XLEN-1:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async read ports, one sync write port
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] regs [NREG];

  // Synchronous clear has priority; r0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents; there is deliberately no write bypass
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_datapath.sv
// rtl/mips_datapath.sv - single-cycle MIPS datapath: PC, next-PC, regfile, ALU, write-back
module mips_datapath
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoreg,
  input  logic        pcsrc,
  input  logic        alusrc,
  input  logic        regdst,
  input  logic        regwrite,
  input  logic        jump,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic        zero,
  output logic [31:0] pc,
  output logic [31:0] aluout,
  output logic [31:0] writedata
);

  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] pcnextbr;
  logic [31:0] pcjump;
  logic [31:0] pcnext;
  logic [31:0] signimm;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] rd2;
  logic [31:0] result;
  logic [31:0] bb;
  logic [31:0] sum;
  logic [4:0]  writereg;

  // The opcode field is decoded by the controller, not here
  logic        opcode_unused;
  assign opcode_unused = ^instr[31:26];

  // Program counter: cleared by reset, otherwise advances every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pcnext;
    end
  end

  // Next-PC selection; jump wins over a taken branch
  assign signimm  = sign_extend16(instr[15:0]);
  assign pcplus4  = pc + PC_STEP;
  assign pcbranch = pcplus4 + (signimm << 2);
  assign pcnextbr = pcsrc ? pcbranch : pcplus4;
  assign pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};
  assign pcnext   = jump ? pcjump : pcnextbr;

  // Destination register and write-back data
  assign writereg = regdst ? instr[15:11] : instr[20:16];
  assign result   = memtoreg ? readdata : aluout;

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (writereg),
    .wd    (result),
    .rd1   (srca),
    .rd2   (rd2)
  );

  assign writedata = rd2;
  assign srcb      = alusrc ? signimm : rd2;

  // F[2] inverts B and injects the carry, turning add into subtract
  assign bb  = alucontrol[2] ? ~srcb : srcb;
  assign sum = srca + bb + {31'b0, alucontrol[2]};

  // Result select; SLT takes the raw sign of the difference, no overflow fix-up
  always_comb begin
    aluout = '0;
    case (alucontrol[1:0])
      2'b00:   aluout = srca & bb;
      2'b01:   aluout = srca | bb;
      2'b10:   aluout = sum;
      default: aluout = {31'b0, sum[31]};
    endcase
  end

  assign zero = (aluout == 32'b0);

endmodule

// File: tb/tb_mips_datapath.sv
// tb/tb_mips_datapath.sv - self-checking bench for mips_datapath
module tb_mips_datapath;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        memtoreg;
  logic        pcsrc;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        jump;
  logic [2:0]  alucontrol;
  logic [31:0] instr;
  logic [31:0] readdata;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] writedata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] last_alu;
  logic        last_zero;
  logic [31:0] last_wd;

  mips_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .alucontrol (alucontrol),
    .instr      (instr),
    .readdata   (readdata),
    .zero       (zero),
    .pc         (pc),
    .aluout     (aluout),
    .writedata  (writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference ALU as the instruction-level meaning of each function code
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic [31:0] t;
    case (f)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: begin t = a - b; return {31'b0, t[31]}; end
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      default: begin t = a + b; return {31'b0, t[31]}; end
    endcase
  endfunction

  // One instruction: drive, check combinational outputs, clock, check new pc
  task automatic step(input logic rst, input logic [31:0] i,
                      input logic mtr, input logic psrc, input logic asrc,
                      input logic rdst, input logic rw, input logic jmp,
                      input logic [2:0] f, input logic [31:0] rdata);
    logic [31:0] a, b, imm, opb, exp_alu, nxt;
    logic [4:0]  dst;
    reset = rst; instr = i; memtoreg = mtr; pcsrc = psrc; alusrc = asrc;
    regdst = rdst; regwrite = rw; jump = jmp; alucontrol = f; readdata = rdata;
    #2;
    a       = m_regs[i[25:21]];
    b       = m_regs[i[20:16]];
    imm     = {{16{i[15]}}, i[15:0]};
    opb     = asrc ? imm : b;
    exp_alu = alu_ref(a, opb, f);
    check_val("pc", pc, m_pc);
    check_val("aluout", aluout, exp_alu);
    check_val("zero", {31'b0, zero}, {31'b0, exp_alu == 32'b0});
    check_val("writedata", writedata, b);
    last_alu = aluout; last_zero = zero; last_wd = writedata;
    if (rst) begin
      m_pc = 32'b0;
      for (int r = 0; r < 32; r++) m_regs[r] = 32'b0;
    end else begin
      nxt = m_pc + 32'd4;
      if (jmp)       nxt = {nxt[31:28], i[25:0], 2'b00};
      else if (psrc) nxt = nxt + imm * 32'd4;
      if (rw) begin
        dst = rdst ? i[15:11] : i[20:16];
        if (dst != 5'd0) m_regs[dst] = mtr ? rdata : exp_alu;
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
    check_val("pc_next", pc, m_pc);
  endtask

  // Read every register through the rt port
  task automatic sweep_regs();
    for (int r = 0; r < 32; r++) begin
      step(1'b0, {6'b0, 5'd0, 5'(r), 16'b0}, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'b0);
    end
  endtask

  initial begin
    reset = 1'b1; instr = '0; memtoreg = 0; pcsrc = 0; alusrc = 0; regdst = 0;
    regwrite = 0; jump = 0; alucontrol = ALU_ADD; readdata = '0;
    m_pc = '0;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    @(posedge clk);
    #1;
    check_val("reset_pc", pc, 32'h0);

    // Sequential fetch
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, ALU_AND, 32'h0);
    check_val("fetch_4", pc, 32'd4);
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, ALU_AND, 32'h0);
    check_val("fetch_8", pc, 32'd8);
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, ALU_AND, 32'h0);
    check_val("fetch_12", pc, 32'd12);

    // addi $2,$0,5 then add $3,$2,$2
    step(0, 32'h20020005, 0, 0, 1, 0, 1, 0, ALU_ADD, 32'h0);
    check_val("addi_alu", last_alu, 32'd5);
    step(0, 32'h00421820, 0, 0, 0, 1, 1, 0, ALU_ADD, 32'h0);
    check_val("add_alu", last_alu, 32'd10);

    // ALU functions with rs=$3 (10), rt=$2 (5)
    step(0, 32'h00620000, 0, 0, 0, 0, 0, 0, ALU_SUB, 32'h0);
    check_val("sub_alu", last_alu, 32'd5);
    check_val("sub_zero", {31'b0, last_zero}, 32'd0);
    step(0, 32'h00620000, 0, 0, 0, 0, 0, 0, ALU_AND, 32'h0);
    check_val("and_alu", last_alu, 32'd0);
    check_val("and_zero", {31'b0, last_zero}, 32'd1);
    step(0, 32'h00620000, 0, 0, 0, 0, 0, 0, ALU_OR, 32'h0);
    check_val("or_alu", last_alu, 32'd15);
    step(0, 32'h00620000, 0, 0, 0, 0, 0, 0, ALU_SLT, 32'h0);
    check_val("slt_alu", last_alu, 32'd0);
    step(0, 32'h00430000, 0, 0, 0, 0, 0, 0, ALU_SLT, 32'h0);
    check_val("slt_swap_alu", last_alu, 32'd1);

    // Branch backwards from pc=8, then jumps
    step(1, 32'h0, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    check_val("pc_before_br", pc, 32'd8);
    step(0, 32'h1000FFFE, 0, 1, 0, 0, 0, 0, ALU_SUB, 32'h0);
    check_val("branch_pc", pc, 32'd4);
    step(0, 32'h08000011, 0, 0, 0, 0, 0, 1, ALU_ADD, 32'h0);
    check_val("jump_pc", pc, 32'h44);
    step(0, 32'h08000011, 0, 1, 0, 0, 0, 1, ALU_ADD, 32'h0);
    check_val("jump_over_br", pc, 32'h44);

    // Load write-back and r0 immunity
    step(0, 32'h8C040000, 1, 0, 1, 0, 1, 0, ALU_ADD, 32'hDEADBEEF);
    step(0, 32'h00040000, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    check_val("lw_r4", last_wd, 32'hDEADBEEF);
    step(0, 32'h8C000000, 1, 0, 1, 0, 1, 0, ALU_ADD, 32'h12345678);
    step(0, 32'h00000000, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    check_val("r0_zero", last_wd, 32'h0);

    // Reset mid-run with a competing register write
    step(0, 32'h08000010, 0, 0, 0, 0, 0, 1, ALU_ADD, 32'h0);
    check_val("pc_40", pc, 32'h40);
    step(1, 32'h8C040000, 1, 0, 1, 0, 1, 0, ALU_ADD, 32'hFFFFFFFF);
    check_val("reset_mid_pc", pc, 32'h0);
    step(0, 32'h00040000, 0, 0, 0, 0, 0, 0, ALU_ADD, 32'h0);
    check_val("reset_mid_r4", last_wd, 32'h0);
    sweep_regs();

    // Randomized instruction stream against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) == 0, $urandom,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           3'($urandom), $urandom);
      if (n % 100 == 99) sweep_regs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
